// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command handshake bus for alu_seq
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [3:0] cmd_imm;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rd,
        output cmd_rs1,
        output cmd_rs2,
        output cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rd,
        input  cmd_rs1,
        input  cmd_rs2,
        input  cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer driving an external 4-bit ALU with 8-bit pair ops
module alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   cmd,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_ov,
    output logic       done,
    output logic       err,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_ov,
    input  logic [1:0] rf_raddr,
    output logic [3:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC_LO,
        EXEC_HI,
        EXEC_FIX,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] rf [4];

    // operands and decoded fields captured at acceptance
    logic [1:0] lat_rd;
    logic       lat_sub;
    logic       is_wide;
    logic [7:0] lat_a8;
    logic [7:0] lat_b8;

    // partial results of a wide op
    logic [3:0] res_lo;
    logic       c_lo;
    logic       c_hi;

    logic [7:0] src_a8;
    logic [7:0] src_b8;
    logic [1:0] rd_lo;
    logic [1:0] rd_hi;
    logic       need_fix;
    logic       wide_c_hi;
    logic       wide_c_fix;
    logic       wide_c;
    logic       wide_z;
    logic       wide_ov;

    assign cmd.cmd_ready = (state == IDLE);
    assign rf_rdata      = rf[rf_raddr];

    assign src_a8 = {rf[{cmd.cmd_rs1[1], 1'b1}], rf[{cmd.cmd_rs1[1], 1'b0}]};
    assign src_b8 = {rf[{cmd.cmd_rs2[1], 1'b1}], rf[{cmd.cmd_rs2[1], 1'b0}]};
    assign rd_lo  = {lat_rd[1], 1'b0};
    assign rd_hi  = {lat_rd[1], 1'b1};

    // the high nibble is computed without carry-in, so a +1/-1 fix-up
    // pass is needed when the low nibble carried (add) or borrowed (sub)
    assign need_fix = lat_sub ? ~c_lo : c_lo;

    // 8-bit flags, evaluated in whichever state completes the wide op;
    // alu_result then holds the final high nibble
    always_comb begin
        wide_c_hi  = (state == EXEC_HI) ? alu_c : c_hi;
        wide_c_fix = (state == EXEC_FIX) ? alu_c : lat_sub;
        wide_c     = lat_sub ? (wide_c_hi & wide_c_fix) : (wide_c_hi | wide_c_fix);
        wide_z     = ({alu_result, res_lo} == 8'h00);
        if (lat_sub)
            wide_ov = (lat_a8[7] != lat_b8[7]) && (alu_result[3] != lat_a8[7]);
        else
            wide_ov = (lat_a8[7] == lat_b8[7]) && (alu_result[3] != lat_a8[7]);
    end

    // control FSM with register file, flags and registered ALU drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
            lat_rd  <= 2'b00;
            lat_sub <= 1'b0;
            is_wide <= 1'b0;
            lat_a8  <= 8'h00;
            lat_b8  <= 8'h00;
            res_lo  <= 4'h0;
            c_lo    <= 1'b0;
            c_hi    <= 1'b0;
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_sel <= 3'b000;
            done    <= 1'b0;
            err     <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_ov <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        lat_rd  <= cmd.cmd_rd;
                        lat_sub <= (cmd.cmd_op == 4'b1010);
                        casez (cmd.cmd_op)
                            4'b0???: begin
                                is_wide <= 1'b0;
                                alu_a   <= rf[cmd.cmd_rs1];
                                alu_b   <= rf[cmd.cmd_rs2];
                                alu_sel <= cmd.cmd_op[2:0];
                                state   <= EXEC_LO;
                            end
                            4'b1000: begin
                                rf[cmd.cmd_rd] <= cmd.cmd_imm;
                                done           <= 1'b1;
                                state          <= DONE;
                            end
                            4'b1001, 4'b1010: begin
                                is_wide <= 1'b1;
                                lat_a8  <= src_a8;
                                lat_b8  <= src_b8;
                                alu_a   <= src_a8[3:0];
                                alu_b   <= src_b8[3:0];
                                alu_sel <= {2'b00, cmd.cmd_op[1]};
                                state   <= EXEC_LO;
                            end
                            default: begin
                                done  <= 1'b1;
                                err   <= 1'b1;
                                state <= DONE;
                            end
                        endcase
                    end
                end
                EXEC_LO: begin
                    if (!is_wide) begin
                        rf[lat_rd] <= alu_result;
                        flag_c     <= alu_c;
                        flag_z     <= alu_z;
                        flag_ov    <= alu_ov;
                        alu_a      <= 4'h0;
                        alu_b      <= 4'h0;
                        alu_sel    <= 3'b000;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        rf[rd_lo] <= alu_result;
                        res_lo    <= alu_result;
                        c_lo      <= alu_c;
                        alu_a     <= lat_a8[7:4];
                        alu_b     <= lat_b8[7:4];
                        state     <= EXEC_HI;
                    end
                end
                EXEC_HI: begin
                    rf[rd_hi] <= alu_result;
                    c_hi      <= alu_c;
                    if (need_fix) begin
                        alu_a <= alu_result;
                        alu_b <= 4'b0001;
                        state <= EXEC_FIX;
                    end else begin
                        flag_c  <= wide_c;
                        flag_z  <= wide_z;
                        flag_ov <= wide_ov;
                        alu_a   <= 4'h0;
                        alu_b   <= 4'h0;
                        alu_sel <= 3'b000;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                EXEC_FIX: begin
                    rf[rd_hi] <= alu_result;
                    flag_c    <= wide_c;
                    flag_z    <= wide_z;
                    flag_ov   <= wide_ov;
                    alu_a     <= 4'h0;
                    alu_b     <= 4'h0;
                    alu_sel   <= 3'b000;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_c;
    logic       alu_z;
    logic       alu_ov;
    logic       done;
    logic       err;
    logic       flag_c;
    logic       flag_z;
    logic       flag_ov;
    logic [1:0] rf_raddr;
    logic [3:0] rf_rdata;

    int total = 0;
    int bad   = 0;

    alu_seq_if cmd_if ();

    alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_ov     (alu_ov),
        .done       (done),
        .err        (err),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_ov    (flag_ov),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external 4-bit ALU: carry is carry-out for add, not-borrow for sub
    logic [4:0] m_sum;
    always_comb begin
        m_sum      = 5'd0;
        alu_result = 4'h0;
        alu_c      = 1'b0;
        alu_ov     = 1'b0;
        case (alu_sel)
            3'd0: begin
                m_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = m_sum[3:0];
                alu_c      = m_sum[4];
                alu_ov     = (alu_a[3] == alu_b[3]) && (m_sum[3] != alu_a[3]);
            end
            3'd1: begin
                m_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result = m_sum[3:0];
                alu_c      = m_sum[4];
                alu_ov     = (alu_a[3] != alu_b[3]) && (m_sum[3] != alu_a[3]);
            end
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 4'h1 : 4'h0;
            default: alu_result = (alu_a == alu_b) ? 4'h1 : 4'h0;
        endcase
        alu_z = (alu_result == 4'h0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        rf_raddr = idx;
        #1;
        check(tag, {28'd0, rf_rdata}, {28'd0, exp});
    endtask

    task automatic check_flags(input string tag, input logic c, input logic z, input logic ov);
        check({tag, "_c"}, {31'd0, flag_c}, {31'd0, c});
        check({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
        check({tag, "_ov"}, {31'd0, flag_ov}, {31'd0, ov});
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm);
        cmd_if.cmd_op  = op;
        cmd_if.cmd_rd  = rd;
        cmd_if.cmd_rs1 = rs1;
        cmd_if.cmd_rs2 = rs2;
        cmd_if.cmd_imm = imm;
    endtask

    // issue one command, return cycles from acceptance to done and err seen with done
    task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [3:0] imm,
                           output int lat, output logic e);
        int n;
        n = 0;
        while (!cmd_if.cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        drive(op, rd, rs1, rs2, imm);
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = err;
        @(posedge clk); #1;
    endtask

    task automatic li(input logic [1:0] rd, input logic [3:0] imm);
        int lat;
        logic e;
        run_cmd(4'b1000, rd, 2'd0, 2'd0, imm, lat, e);
        check("li_lat", lat, 1);
    endtask

    int   lat;
    logic e;

    initial begin
        rst_n            = 1'b0;
        rf_raddr         = 2'd0;
        cmd_if.cmd_valid = 1'b0;
        drive(4'h0, 2'd0, 2'd0, 2'd0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check("rst_ready", {31'd0, cmd_if.cmd_ready}, 1);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_alu_a", {28'd0, alu_a}, 0);
        check("rst_alu_sel", {29'd0, alu_sel}, 0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 4'h0);

        // narrow add: 7 + 5 = C with signed overflow
        li(2'd0, 4'h7);
        li(2'd1, 4'h5);
        run_cmd(4'b0000, 2'd2, 2'd0, 2'd1, 4'h0, lat, e);
        check("add_lat", lat, 2);
        check("add_err", {31'd0, e}, 0);
        check_reg("add_r2", 2'd2, 4'hC);
        check_flags("add", 1'b0, 1'b0, 1'b1);

        // LI leaves flags alone; narrow sub with rd == rs1
        li(2'd0, 4'h5);
        check_flags("li_keep", 1'b0, 1'b0, 1'b1);
        run_cmd(4'b0001, 2'd0, 2'd0, 2'd1, 4'h0, lat, e);
        check("sub_lat", lat, 2);
        check_reg("sub_r0", 2'd0, 4'h0);
        check_flags("sub", 1'b1, 1'b1, 1'b0);

        // illegal op: done+err after one cycle, nothing written
        run_cmd(4'b1111, 2'd0, 2'd1, 2'd1, 4'hA, lat, e);
        check("ill_lat", lat, 1);
        check("ill_err", {31'd0, e}, 1);
        check("ill_err_clr", {31'd0, err}, 0);
        check_reg("ill_r0", 2'd0, 4'h0);
        check_reg("ill_r1", 2'd1, 4'h5);
        check_reg("ill_r2", 2'd2, 4'hC);
        check_flags("ill", 1'b1, 1'b1, 1'b0);

        // xor, signed less-than, equal
        li(2'd0, 4'h6);
        li(2'd1, 4'h8);
        run_cmd(4'b0101, 2'd3, 2'd0, 2'd1, 4'h0, lat, e);
        check_reg("xor_r3", 2'd3, 4'hE);
        run_cmd(4'b0110, 2'd3, 2'd1, 2'd0, 4'h0, lat, e);
        check_reg("slt_r3", 2'd3, 4'h1);
        run_cmd(4'b0111, 2'd2, 2'd3, 2'd3, 4'h0, lat, e);
        check_reg("eq_r2", 2'd2, 4'h1);

        // ADD8 0x3F + 0x01 = 0x40 through the fix-up pass
        li(2'd0, 4'hF);
        li(2'd1, 4'h3);
        li(2'd2, 4'h1);
        li(2'd3, 4'h0);
        run_cmd(4'b1001, 2'd0, 2'd0, 2'd2, 4'h0, lat, e);
        check("add8_lat", lat, 4);
        check_reg("add8_r0", 2'd0, 4'h0);
        check_reg("add8_r1", 2'd1, 4'h4);
        check_flags("add8", 1'b0, 1'b0, 1'b0);

        // SUB8 0x10 - 0x01 = 0x0F
        li(2'd0, 4'h0);
        li(2'd1, 4'h1);
        run_cmd(4'b1010, 2'd0, 2'd0, 2'd2, 4'h0, lat, e);
        check("sub8a_lat", lat, 4);
        check_reg("sub8a_r0", 2'd0, 4'hF);
        check_reg("sub8a_r1", 2'd1, 4'h0);
        check_flags("sub8a", 1'b1, 1'b0, 1'b0);

        // SUB8 0x00 - 0x01 = 0xFF into P1, which is also the subtrahend
        li(2'd0, 4'h0);
        run_cmd(4'b1010, 2'd2, 2'd0, 2'd2, 4'h0, lat, e);
        check("sub8b_lat", lat, 4);
        check_reg("sub8b_r2", 2'd2, 4'hF);
        check_reg("sub8b_r3", 2'd3, 4'hF);
        check_flags("sub8b", 1'b0, 1'b0, 1'b0);

        // ADD8 0x80 + 0x80 = 0x00: no fix-up, carry, zero, overflow
        li(2'd1, 4'h8);
        li(2'd2, 4'h0);
        li(2'd3, 4'h8);
        run_cmd(4'b1001, 2'd2, 2'd0, 2'd2, 4'h0, lat, e);
        check("add8b_lat", lat, 3);
        check_reg("add8b_r2", 2'd2, 4'h0);
        check_reg("add8b_r3", 2'd3, 4'h0);
        check_flags("add8b", 1'b1, 1'b1, 1'b1);

        // cmd_valid held through a busy ADD8 (0x3F + 0x21 = 0x60)
        li(2'd0, 4'hF);
        li(2'd1, 4'h3);
        li(2'd2, 4'h1);
        li(2'd3, 4'h2);
        drive(4'b1001, 2'd0, 2'd0, 2'd2, 4'h0);
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        drive(4'b1000, 2'd3, 2'd0, 2'd0, 4'h9);
        for (int k = 1; k <= 3; k++) begin
            check("busy_ready", {31'd0, cmd_if.cmd_ready}, 0);
            check("busy_done", {31'd0, done}, 0);
            @(posedge clk); #1;
        end
        check("busy_done_t4", {31'd0, done}, 1);
        check_reg("busy_r3_hold", 2'd3, 4'h2);
        @(posedge clk); #1;
        check("busy_idle_ready", {31'd0, cmd_if.cmd_ready}, 1);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("busy_li_done", {31'd0, done}, 1);
        check_reg("busy_r0", 2'd0, 4'h0);
        check_reg("busy_r1", 2'd1, 4'h6);
        check_reg("busy_r3", 2'd3, 4'h9);
        @(posedge clk); #1;

        // reset during EXEC_HI of an ADD8
        run_cmd(4'b0001, 2'd3, 2'd3, 2'd3, 4'h0, lat, e);
        check("pre_rst_z", {31'd0, flag_z}, 1);
        li(2'd0, 4'hF);
        li(2'd1, 4'h3);
        li(2'd2, 4'h1);
        drive(4'b1001, 2'd0, 2'd0, 2'd2, 4'h0);
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("abort_lo_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        check("abort_hi_done", {31'd0, done}, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", {31'd0, cmd_if.cmd_ready}, 1);
        check("abort_err", {31'd0, err}, 0);
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_reg("abort_reg", 2'(i), 4'h0);
        for (int k = 0; k < 3; k++) begin
            check("abort_no_done", {31'd0, done}, 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 4; cmd_rd, cmd_rs1, cmd_rs2 in 2 each; cmd_imm in 4.
REQ-004 SHALL have ALU drive ports: alu_a out 4; alu_b out 4; alu_sel out 3.
REQ-005 SHALL have ALU return ports: alu_result in 4; alu_c, alu_z, alu_ov in 1, all combinational functions of alu_a/alu_b/alu_sel.
REQ-006 SHALL have ALU select codes: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-007 SHALL have status ports: done out 1, one-cycle pulse; err out 1; flag_c, flag_z, flag_ov out 1 each, registered.
REQ-008 SHALL have debug port: rf_raddr in 2; rf_rdata out 4, a combinational read of R[rf_raddr].

Function
REQ-009 SHALL contain register file R0..R3, 4 bits each; pairs P0={R1,R0}, P1={R3,R2}; pair index = bit 1 of cmd_rd/rs1/rs2.
REQ-010 SHALL decode cmd_op:
- 0xxx: narrow op, alu_sel=op[2:0], R[rd] <= f(R[rs1],R[rs2]).
- 1000: LI, R[rd] <= cmd_imm.
- 1001: ADD8 on pairs.
- 1010: SUB8 on pairs.
- 1011-1111: illegal.
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid && cmd_ready; cmd_valid while busy is ignored.
REQ-012 SHALL latch all source operands and decoded fields at acceptance; later register writes never change them.
REQ-013 SHALL implement states IDLE, EXEC_LO, EXEC_HI, EXEC_FIX, DONE; DONE always returns to IDLE.
REQ-014 SHALL, for a narrow op accepted in cycle T:
- EXEC_LO in T+1: R[rd], flag_c/z/ov <= alu_result/alu_c/alu_z/alu_ov at end of T+1.
- done=1 in T+2.
REQ-015 SHALL, for LI, write R[rd] at end of the accept cycle, leave flags unchanged, and assert done in T+1.
REQ-016 SHALL, for an illegal op, write no register and change no flag, and assert done=1 with err=1 in T+1.
REQ-017 SHALL run ADD8 (sel 000) and SUB8 (sel 001) as follows:
- EXEC_LO: low nibbles, write rd_lo, save c_lo.
- EXEC_HI: high nibbles, write rd_hi, save c_hi.
- EXEC_FIX: taken only if ADD8 && c_lo=1, or SUB8 && c_lo=0; a=new R[rd_hi], b=0001, same sel, write rd_hi, capture c_fix.
REQ-018 SHALL assert done at T+3 without EXEC_FIX and at T+4 with EXEC_FIX.
REQ-019 SHALL set wide flags at DONE entry:
- z = 8-bit result == 0.
- flag_c: ADD8 = c_hi | c_fix; SUB8 = c_hi & c_fix; c_fix counts as 0 (ADD8) or 1 (SUB8) when EXEC_FIX is skipped.
- ov: ADD8 = (a7==b7)&&(r7!=a7); SUB8 = (a7!=b7)&&(r7!=a7).
REQ-020 SHALL drive alu_a=0, alu_b=0, alu_sel=000 in IDLE and DONE.
REQ-021 SHALL assert err only together with done.
REQ-022 SHALL, when rd equals rs1 or rs2, use the pre-write value, because operands are latched at acceptance.

Reset
REQ-023 SHALL, with rst_n=0 at a clock edge in any state, go to IDLE with R0..R3=0, flags=0, done=0, err=0.
REQ-024 SHALL give reset priority over any register or flag write in the same cycle; an aborted command produces no done.
REQ-025 SHALL present cmd_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-026 SHALL cover: LI R0=7, LI R1=5, op 0000 rd=2 rs1=0 rs2=1 -> R2=C, c=0, z=0, ov=1, done at accept+2.
REQ-027 SHALL cover: R0=5, R1=5, op 0001 rd=0 -> R0=0, z=1, c=1, ov=0.
REQ-028 SHALL cover: P0=0x3F, P1=0x01, ADD8 rd=P0 -> P0=0x40, EXEC_FIX visited, done at accept+4, c=0, z=0, ov=0.
REQ-029 SHALL cover: SUB8 0x10-0x01 -> 0x0F, c=1; and 0x00-0x01 -> 0xFF, c=0, ov=0.
REQ-030 SHALL cover: op 1111 -> done=err=1 at accept+1, registers unchanged; cmd_valid held during a busy ADD8 is not accepted until IDLE.
REQ-031 SHALL cover: rst_n=0 during EXEC_HI of ADD8 -> all registers 0, no done, cmd_ready=1 after release.
